// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with a clear engine.
// Width and depth are configurable, the value returned on a write is
// selectable (old word or new data), and an optional output register
// adds one cycle of read latency. After reset (optionally) and on clr_i
// the whole array is overwritten with INIT_VALUE, one word per cycle,
// while busy_o is high and all requests are ignored.
//
// Handshake: an access is accepted on a rising edge where req_i=1, the
// block is not clearing and clr_i=0. Every accepted access (read or
// write) produces exactly one rvalid_o pulse, 1 cycle later (OUT_REG=0)
// or 2 cycles later (OUT_REG=1), in acceptance order. There is no
// back-pressure: one access per cycle is always accepted when ready.
// err_o is only ever high together with rvalid_o.
module ram_sp_param #(
    parameter int                DATA_W         = 8,
    parameter int                DEPTH          = 32,
    parameter int                ADDR_W         = $clog2(DEPTH),
    parameter int                WRITE_MODE     = 0,
    parameter int                OUT_REG        = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              dbg_state_o
);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int unsigned       DEPTH_U   = DEPTH;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;
    logic              clear_we;
    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ret_word;

    // Stage-1 return registers (the only stage when OUT_REG=0).
    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    // FSM state and clear-address register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // Next-state logic: sweep the array while clearing, otherwise accept
    // accesses; clr_i wins over req_i and drops that access.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        clear_we     = 1'b0;
        accept       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we = 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                end else begin
                    clr_addr_nxt = clr_addr + ADDR_W'(1);
                end
            end
            default: begin
                if (clr_i) begin
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                end else if (req_i) begin
                    accept = 1'b1;
                end
            end
        endcase
    end

    // Address decode and the word returned for the access being accepted.
    // Out-of-range addresses never touch the array and return zero.
    always_comb begin
        in_range = (32'(addr_i) < DEPTH_U);
        rd_word  = '0;
        if (in_range) begin
            rd_word = mem[addr_i];
        end
        ret_word = rd_word;
        if (wen_i && (WRITE_MODE != 0) && in_range) begin
            ret_word = din_i;
        end
    end

    // Array write port: the clear sweep or an accepted in-range write.
    always_ff @(posedge clk_i) begin
        if (clear_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (accept && wen_i && in_range) begin
            mem[addr_i] <= din_i;
        end
    end

    // First return stage; data holds between accepted accesses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && !in_range;
            if (accept) begin
                s1_data <= ret_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic              s2_err;
            logic [DATA_W-1:0] s2_data;

            // Optional output stage: delays stage 1 by one cycle.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout_o   = s2_data;
            assign rvalid_o = s2_valid;
            assign err_o    = s2_err;
        end else begin : g_no_out_reg
            assign dout_o   = s1_data;
            assign rvalid_o = s1_valid;
            assign err_o    = s1_err;
        end
    endgenerate

    assign busy_o      = (state == ST_CLEAR);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_ram_sp_param.sv
// Testbench for ram_sp_param. Three configurations share one stimulus
// stream; each has its own reference model and expected queue.
//   dut 0: DEPTH=32, read-first,  no output reg, INIT=A5
//   dut 1: DEPTH=20, write-first, output reg,    INIT=3C
//   dut 2: DEPTH=24, write-first, no output reg, INIT=00
module tb_ram_sp_param;

    localparam int N  = 3;
    localparam int EW = 25;   // {due cycle[15:0], err, data[7:0]}

    localparam int         DEP  [N] = '{32, 20, 24};
    localparam int         WM   [N] = '{0, 1, 1};
    localparam int         ORG  [N] = '{0, 1, 0};
    localparam logic [7:0] INIT [N] = '{8'hA5, 8'h3C, 8'h00};

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       wen = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] din = '0;

    logic [7:0] dout   [N];
    logic       rvalid [N];
    logic       err    [N];
    logic       busy   [N];
    logic       st     [N];

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_W(8), .DEPTH(32), .WRITE_MODE(0), .OUT_REG(0),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(8'hA5)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr),
        .din_i(din), .clr_i(clr), .dout_o(dout[0]), .rvalid_o(rvalid[0]),
        .err_o(err[0]), .busy_o(busy[0]), .dbg_state_o(st[0]));

    ram_sp_param #(.DATA_W(8), .DEPTH(20), .WRITE_MODE(1), .OUT_REG(1),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(8'h3C)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr),
        .din_i(din), .clr_i(clr), .dout_o(dout[1]), .rvalid_o(rvalid[1]),
        .err_o(err[1]), .busy_o(busy[1]), .dbg_state_o(st[1]));

    ram_sp_param #(.DATA_W(8), .DEPTH(24), .WRITE_MODE(1), .OUT_REG(0),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(8'h00)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr),
        .din_i(din), .clr_i(clr), .dout_o(dout[2]), .rvalid_o(rvalid[2]),
        .err_o(err[2]), .busy_o(busy[2]), .dbg_state_o(st[2]));

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q [N][$];
    logic [7:0]    mdl_mem  [N][32];
    int            busy_cnt [N];
    logic [7:0]    last_dout[N];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference model: whole-array clear is instantaneous, busy is a
    // countdown, accesses are array lookups returning after a fixed latency.
    task automatic model_step();
        logic [7:0] d;
        logic       e;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                exp_q[k].delete();
                busy_cnt[k] = DEP[k];
                for (int a = 0; a < 32; a++) mdl_mem[k][a] = INIT[k];
            end else if (busy_cnt[k] > 0) begin
                busy_cnt[k]--;
            end else if (clr) begin
                busy_cnt[k] = DEP[k];
                for (int a = 0; a < 32; a++) mdl_mem[k][a] = INIT[k];
            end else if (req) begin
                if (int'(addr) < DEP[k]) begin
                    d = mdl_mem[k][addr];
                    if (wen) begin
                        if (WM[k] == 1) d = din;
                        mdl_mem[k][addr] = din;
                    end
                    e = 1'b0;
                end else begin
                    d = 8'h00;
                    e = 1'b1;
                end
                exp_q[k].push_back({16'(cyc + ORG[k]), e, d});
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: sampled 1 time unit after each rising edge.
    task automatic monitor_step();
        logic [EW-1:0] ent;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                last_dout[k] = 8'h00;
                continue;
            end
            chk("busy", k, 32'(busy[k]), 32'(busy_cnt[k] > 0));
            if (rvalid[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("unexpected_rvalid", k, 32'(rvalid[k]), 32'd0);
                end else begin
                    ent = exp_q[k].pop_front();
                    chk("latency_cycle", k, 32'(cyc), 32'(ent[24:9]));
                    chk("dout", k, 32'(dout[k]), 32'(ent[7:0]));
                    chk("err", k, 32'(err[k]), 32'(ent[8]));
                    last_dout[k] = ent[7:0];
                end
            end else begin
                chk("err_idle", k, 32'(err[k]), 32'd0);
                chk("dout_hold", k, 32'(dout[k]), 32'(last_dout[k]));
                if (exp_q[k].size() != 0) begin
                    ent = exp_q[k][0];
                    if (int'(ent[24:9]) <= cyc) begin
                        chk("missing_rvalid", k, 32'(rvalid[k]), 32'd1);
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        monitor_step();
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic access(input logic w, input logic [4:0] a, input logic [7:0] d,
                          input logic c);
        req  = 1'b1;
        wen  = w;
        addr = a;
        din  = d;
        clr  = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        wen = 1'b0;
        clr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int  i;
        logic done;
        req  = 1'b0;
        clr  = 1'b0;
        done = 1'b0;
        for (i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !(busy[0] || busy[1] || busy[2]);
        end
        if (!done) chk("wait_ready_timeout", 0, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        req = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rst_dout", k, 32'(dout[k]), 32'd0);
            chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
            chk("rst_err", k, 32'(err[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_busy", k, 32'(busy[k]), 32'd1);
            chk("reset_dout", k, 32'(dout[k]), 32'd0);
        end
        rst = 1'b0;

        // A request while clearing is ignored.
        idle(5);
        access(1'b0, 5'd0, 8'h00, 1'b0);
        access(1'b1, 5'd3, 8'h44, 1'b0);
        wait_ready();

        // Cleared contents at both ends.
        access(1'b0, 5'd0, 8'h00, 1'b0);
        access(1'b0, 5'd31, 8'h00, 1'b0);
        idle(3);

        // Write then read, read of a cleared word.
        access(1'b1, 5'd1, 8'd7, 1'b0);
        access(1'b0, 5'd1, 8'h00, 1'b0);
        access(1'b0, 5'd2, 8'h00, 1'b0);
        idle(2);

        // Write-mode return value.
        access(1'b1, 5'd2, 8'd8, 1'b0);
        idle(1);
        access(1'b1, 5'd2, 8'd9, 1'b0);
        access(1'b0, 5'd2, 8'h00, 1'b0);
        idle(2);

        // Back-to-back reads.
        access(1'b0, 5'd0, 8'h00, 1'b0);
        access(1'b0, 5'd1, 8'h00, 1'b0);
        access(1'b0, 5'd2, 8'h00, 1'b0);
        idle(3);

        // Out-of-range and top-of-range.
        access(1'b1, 5'd25, 8'h5A, 1'b0);
        access(1'b0, 5'd25, 8'h00, 1'b0);
        access(1'b1, 5'd19, 8'h13, 1'b0);
        access(1'b0, 5'd19, 8'h00, 1'b0);
        idle(2);

        // clr_i beats a simultaneous write.
        access(1'b1, 5'd4, 8'h77, 1'b0);
        access(1'b1, 5'd4, 8'd3, 1'b1);
        wait_ready();
        access(1'b0, 5'd4, 8'h00, 1'b0);
        idle(3);

        // Reset halfway through a clear.
        access(1'b0, 5'd0, 8'h00, 1'b1);
        idle(10);
        do_reset();
        wait_ready();
        access(1'b0, 5'd5, 8'h00, 1'b0);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       8'($urandom), 1'b1);
            end else if (r < 70) begin
                access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       8'($urandom), 1'b0);
            end else begin
                idle(1);
            end
        end
        idle(5);

        for (int k = 0; k < N; k++) begin
            chk("queue_drained", k, 32'(exp_q[k].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
